// File: rtl/proc_pkg.sv
// Shared constants for the parametrised bus processor: opcodes, step codes
// and bus-source selects.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } step_t;

    localparam logic [3:0] SEL_R0   = 4'd0;
    localparam logic [3:0] SEL_R7   = 4'd7;
    localparam logic [3:0] SEL_DIN  = 4'd8;
    localparam logic [3:0] SEL_G    = 4'd9;
    localparam logic [3:0] SEL_NONE = 4'd10;

    // Register k is bus source k, so the select is just the zero-extended index.
    function automatic logic [3:0] sel_reg(input logic [2:0] k);
        return {1'b0, k};
    endfunction

    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/proc_param_regn_r.sv
// Generic load-enabled register with asynchronous active-low clear; used for
// R0-R7, A, G and IR.
module regn_r #(
    parameter int W = 9
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage element: clear on reset, load when enabled, otherwise hold.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/proc_param.sv
// Multi-cycle bus processor with N-bit datapath: R0-R7, A, G, a shared bus and
// a Run-gated T0-T3 step machine executing one instruction per start.
module proc_param
    import proc_pkg::*;
#(
    parameter int N = 9
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    output logic         Done,
    output logic [N-1:0] BusWires
);

    step_t        step_r;
    step_t        step_nxt_s;
    logic [8:0]   ir_q_s;
    logic [N-1:0] r_q_s [8];
    logic [N-1:0] a_q_s;
    logic [N-1:0] g_q_s;
    logic [N-1:0] bus_s;
    logic [N-1:0] alu_s;
    logic [7:0]   r_in_s;
    logic         a_in_s;
    logic         g_in_s;
    logic         ir_in_s;
    logic         done_s;
    logic [3:0]   sel_s;
    logic [2:0]   op_s;
    logic [2:0]   x_s;
    logic [2:0]   y_s;

    assign op_s = ir_q_s[8:6];
    assign x_s  = ir_q_s[5:3];
    assign y_s  = ir_q_s[2:0];

    regn_r #(.W(9)) u_ir (
        .Clock (Clock), .Resetn (Resetn), .en (ir_in_s), .d (DIN[8:0]), .q (ir_q_s)
    );

    for (genvar k = 0; k < 8; k++) begin : g_regs
        regn_r #(.W(N)) u_r (
            .Clock (Clock), .Resetn (Resetn), .en (r_in_s[k]), .d (bus_s), .q (r_q_s[k])
        );
    end

    regn_r #(.W(N)) u_a (
        .Clock (Clock), .Resetn (Resetn), .en (a_in_s), .d (bus_s), .q (a_q_s)
    );

    regn_r #(.W(N)) u_g (
        .Clock (Clock), .Resetn (Resetn), .en (g_in_s), .d (alu_s), .q (g_q_s)
    );

    // Step register; an async reset abandons any instruction in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_r <= T0;
        end else begin
            step_r <= step_nxt_s;
        end
    end

    // Step sequencing and control decode from (step, IR, G).
    always_comb begin
        step_nxt_s = T0;
        ir_in_s    = 1'b0;
        a_in_s     = 1'b0;
        g_in_s     = 1'b0;
        r_in_s     = 8'b0;
        done_s     = 1'b0;
        sel_s      = SEL_NONE;
        case (step_r)
            T0: begin
                ir_in_s    = Run;
                step_nxt_s = Run ? T1 : T0;
            end
            T1: begin
                case (op_s)
                    OP_MV: begin
                        sel_s         = sel_reg(y_s);
                        r_in_s[x_s]   = 1'b1;
                        done_s        = 1'b1;
                    end
                    OP_MVI: begin
                        sel_s         = SEL_DIN;
                        r_in_s[x_s]   = 1'b1;
                        done_s        = 1'b1;
                    end
                    OP_MVNZ: begin
                        if (g_q_s != {N{1'b0}}) begin
                            sel_s       = sel_reg(y_s);
                            r_in_s[x_s] = 1'b1;
                        end else begin
                            sel_s       = SEL_NONE;
                        end
                        done_s        = 1'b1;
                    end
                    OP_NOP: begin
                        done_s        = 1'b1;
                    end
                    default: begin
                        sel_s         = sel_reg(x_s);
                        a_in_s        = 1'b1;
                        step_nxt_s    = T2;
                    end
                endcase
            end
            T2: begin
                if (is_alu(op_s)) begin
                    sel_s      = sel_reg(y_s);
                    g_in_s     = 1'b1;
                    step_nxt_s = T3;
                end else begin
                    step_nxt_s = T0;
                end
            end
            T3: begin
                if (is_alu(op_s)) begin
                    sel_s       = SEL_G;
                    r_in_s[x_s] = 1'b1;
                    done_s      = 1'b1;
                end else begin
                    done_s      = 1'b0;
                end
            end
            default: begin
                step_nxt_s = T0;
            end
        endcase
    end

    // Bus mux: a single source per step, zero when nothing drives it.
    always_comb begin
        bus_s = {N{1'b0}};
        if (sel_s <= SEL_R7) begin
            bus_s = r_q_s[sel_s[2:0]];
        end else if (sel_s == SEL_DIN) begin
            bus_s = DIN;
        end else if (sel_s == SEL_G) begin
            bus_s = g_q_s;
        end else begin
            bus_s = {N{1'b0}};
        end
    end

    // ALU feeding G; arithmetic wraps modulo 2^N.
    always_comb begin
        alu_s = {N{1'b0}};
        case (op_s)
            OP_ADD:  alu_s = a_q_s + bus_s;
            OP_SUB:  alu_s = a_q_s - bus_s;
            OP_AND:  alu_s = a_q_s & bus_s;
            OP_OR:   alu_s = a_q_s | bus_s;
            default: alu_s = a_q_s + bus_s;
        endcase
    end

    assign Done     = done_s;
    assign BusWires = bus_s;

endmodule

// File: doc/proc_param.md
Name: proc_param

Overview:
- Parametrised successor of the 9-bit multi-cycle bus processor: eight general registers R0-R7, an A register, an adder/subtractor/logic unit feeding G, and a shared bus.
- Data width N is a parameter. Adds AND, OR, conditional move (mvnz) and nop to mv/mvi/add/sub.
- A Run-gated step FSM (T0-T3) executes one instruction per Run-start and reports completion on Done.
- Top-level datapath of the lab processor chain; DIN is driven by a counter/memory front end.

Parameters:
- N, 9, data/bus width in bits; must be >= 9. The instruction occupies DIN[8:0].

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Run  input  1  start request; sampled only in T0.
- DIN  input  N  instruction word in T0 (DIN[8:0] = III XXX YYY); immediate operand in T1 for mvi.
- Done  output  1  high during the final step of an instruction.
- BusWires  output  N  shared bus value (observable).

Behaviour:
- Reset (async, Resetn=0): Tstep=T0, IR=0, R0-R7=0, A=0, G=0. Outputs are then Done=0 and BusWires=0. Reset takes effect from any step, including mid-instruction; the partial instruction is discarded.
- Opcodes (III): 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 or, 110 mvnz, 111 nop.
- Bus: exactly one source per step (Rk, DIN, G). When no source is selected, the bus is 0.
- Done and all enables are combinational decodes of (Tstep, IR, G). Rin[k], Ain, Gin and IRin take effect on the next rising edge.
- T0:
  - IRin = Run.
  - If Run=1: IR <= DIN[8:0], next T1. Otherwise stay in T0.
  - Done=0.
- T1:
  - mv: bus=RY, Rin[X]=1, Done=1, next T0.
  - mvi: bus=DIN, Rin[X]=1, Done=1, next T0.
  - add/sub/and/or: bus=RX, Ain=1, next T2.
  - mvnz: if G!=0 then bus=RY and Rin[X]=1; else bus=0 and no write. Done=1, next T0.
  - nop: Done=1, next T0.
- T2 (ALU ops):
  - bus=RY, Gin=1, next T3.
  - G <= A+bus (add), A-bus (sub), A&bus (and), or A|bus (or).
  - Arithmetic is modulo 2^N; no carry or overflow is kept.
- T3 (ALU ops): bus=G, Rin[X]=1, Done=1, next T0.
- Run is ignored after T0: once an instruction starts, dropping Run does not abort it.
- Run held high in the Done step: the next instruction is captured in the following T0 cycle. There is no T0 bypass; T0 always costs one cycle.
- Latency, counted from the T0 capture edge:
  - mv/mvi/mvnz/nop: 2 cycles (T0, T1).
  - ALU ops: 4 cycles (T0-T3).
- X=Y is legal:
  - mv R3,R3 leaves R3 unchanged.
  - sub R3,R3 writes 0.
- Write and read of the same register in one step: the bus carries the old value; the new value is visible from the next cycle.
- Illegal Tstep encodings (unreachable) return to T0.

Decomposition:
- Package proc_pkg:
  - Opcode constants (OP_MV..OP_NOP).
  - Step encodings T0-T3 (2-bit).
  - Bus-select encoding (SEL_R0..SEL_R7, SEL_DIN, SEL_G, SEL_NONE).
- Sub-module regn_r: N-bit register with load enable and async active-low clear. Instantiated for R0-R7, A, G, and the 9-bit IR.
- ALU and bus mux stay inline in proc_param.

Test Plan:
- Reset: Resetn=0 asserted mid-T2 of an add → Tstep=T0, Done=0, BusWires=0; after release all of R0-R7/A/G read 0.
- mvi/mv (N=9):
  - Run=1, DIN=001_000_000, then DIN=5 → Done=1 with BusWires=5 in T1; R0=5.
  - Then DIN=000_001_000 → BusWires=5, Done in T1; R1=5.
- add/sub wrap:
  - add R0,R1 (5+5) → BusWires=10 with Done in T3, 4 cycles after capture; R0=10.
  - sub R2,R0 (0-10) → R2=9'h1F6.
- Logic:
  - R3=9'h0F3, R4=9'h13C.
  - and R3,R4 → R3=9'h030.
  - or R4,R3 (R3=9'h030, R4=9'h13C) → R4=9'h13C.
- mvnz:
  - After sub R5,R5 (G=0), mvnz R6,R0 → R6 unchanged, Done=1.
  - After add giving G=7, mvnz R6,R0 → R6=R0.
- Run handling:
  - Run=0 in T0 for 5 cycles → stays T0, Done=0.
  - Run dropped in T2 of add → instruction completes in T3 with Done=1.
